// File: rtl/axi_rd_arb_if.sv
// Bundles the requester ports and the AXI AR/R channels of the read arbiter.
// "master" is the arbiter side (AXI master); "slave" is the requesters plus memory.
interface axi_rd_arb_if #(
   parameter int NPORT = 3,
   parameter int IDW   = 16
);
   logic [NPORT-1:0]      req_valid;
   logic [64*NPORT-1:0]   req_addr;
   logic [8*NPORT-1:0]    req_len;
   logic [NPORT-1:0]      req_ready;
   logic [511:0]          rsp_data;
   logic [NPORT-1:0]      rsp_valid;
   logic                  rsp_last;
   logic                  rsp_err;
   logic [NPORT-1:0]      rsp_ready;
   logic [IDW-1:0]        arid_m;
   logic [63:0]           araddr_m;
   logic [7:0]            arlen_m;
   logic [2:0]            arsize_m;
   logic                  arvalid_m;
   logic                  arready_m;
   logic [IDW-1:0]        rid_m;
   logic [511:0]          rdata_m;
   logic [1:0]            rresp_m;
   logic                  rlast_m;
   logic                  rvalid_m;
   logic                  rready_m;

   modport master (
      input  req_valid, req_addr, req_len, rsp_ready,
      input  arready_m, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
      output req_ready, rsp_data, rsp_valid, rsp_last, rsp_err,
      output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m, rready_m
   );

   modport slave (
      output req_valid, req_addr, req_len, rsp_ready,
      output arready_m, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
      input  req_ready, rsp_data, rsp_valid, rsp_last, rsp_err,
      input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m, rready_m
   );
endinterface

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter funnelling NPORT burst requesters onto one AXI read port,
// with a single burst in flight and sticky error reporting.
module axi_rd_arb #(
   parameter int NPORT = 3,
   parameter int IDW   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   axi_rd_arb_if.master bus,
   output logic        busy,
   output logic [1:0]  err_sticky
);
   localparam int GW = 2;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t          state_reg, state_next;
   logic [GW-1:0]   last_grant_reg, last_grant_next;
   logic [GW-1:0]   grant_reg, grant_next;
   logic [63:0]     addr_reg, addr_next;
   logic [7:0]      len_reg, len_next;
   logic [7:0]      beat_reg, beat_next;
   logic [1:0]      err_reg, err_next;

   logic [GW-1:0]   winner;
   logic [GW-1:0]   cand;
   logic            found;
   logic            hs;
   logic [NPORT-1:0] req_ready_c;
   int              idx;

   // Rotating priority: the port just after the last winner is considered first.
   always_comb begin
      winner = last_grant_reg;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int k = 1; k <= NPORT; k++) begin
         idx = int'(last_grant_reg) + k;
         if (idx >= NPORT) idx = idx - NPORT;
         cand = GW'(idx);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      grant_next      = grant_reg;
      addr_next       = addr_reg;
      len_next        = len_reg;
      beat_next       = beat_reg;
      err_next        = err_reg;
      req_ready_c     = '0;
      hs              = 1'b0;
      bus.arvalid_m   = 1'b0;
      bus.rready_m    = 1'b0;
      bus.rsp_valid   = '0;
      bus.rsp_data    = '0;
      bus.rsp_last    = 1'b0;
      bus.rsp_err     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (found) begin
               req_ready_c = NPORT'(1) << winner;
               grant_next  = winner;
               addr_next   = bus.req_addr[64*winner +: 64];
               len_next    = bus.req_len[8*winner +: 8];
               state_next  = ADDR;
            end
         end
         ADDR: begin
            bus.arvalid_m = 1'b1;
            if (bus.arready_m) begin
               state_next = DATA;
               beat_next  = '0;
            end
         end
         DATA: begin
            bus.rready_m             = bus.rsp_ready[grant_reg];
            bus.rsp_valid[grant_reg] = bus.rvalid_m;
            bus.rsp_data             = bus.rdata_m;
            bus.rsp_last             = bus.rlast_m;
            bus.rsp_err              = (bus.rresp_m != 2'b00);
            hs = bus.rvalid_m & bus.rsp_ready[grant_reg];
            if (hs) begin
               beat_next = beat_reg + 8'd1;
               if (bus.rresp_m != 2'b00) err_next[0] = 1'b1;
               // Protocol checks only flag; burst termination follows rlast alone.
               if ((bus.rid_m != bus.arid_m) ||
                   (bus.rlast_m && (beat_reg != len_reg)) ||
                   (!bus.rlast_m && (beat_reg == len_reg)))
                  err_next[1] = 1'b1;
               if (bus.rlast_m) begin
                  state_next      = IDLE;
                  last_grant_next = grant_reg;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= GW'(NPORT-1);
         grant_reg      <= '0;
         addr_reg       <= '0;
         len_reg        <= '0;
         beat_reg       <= '0;
         err_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         grant_reg      <= grant_next;
         addr_reg       <= addr_next;
         len_reg        <= len_next;
         beat_reg       <= beat_next;
         err_reg        <= err_next;
      end
   end

   // Grant is combinational from req_valid, so it is masked while reset is held.
   assign bus.req_ready = req_ready_c & {NPORT{rst_n}};
   assign bus.arid_m    = IDW'(grant_reg);
   assign bus.araddr_m  = addr_reg;
   assign bus.arlen_m   = len_reg;
   assign bus.arsize_m  = 3'd6;
   assign busy          = (state_reg != IDLE);
   assign err_sticky    = err_reg;
endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: single bursts, round-robin order, back-pressure,
// error flags and asynchronous reset in mid-burst.
module tb_axi_rd_arb;
   logic       clk;
   logic       rst_n;
   logic       busy;
   logic [1:0] err_sticky;
   int         n_checks;
   int         n_errors;

   axi_rd_arb_if #(.NPORT(3), .IDW(16)) bus ();

   axi_rd_arb #(.NPORT(3), .IDW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.master),
      .busy       (busy),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Entered at a clock low phase with the request already presented; returns
   // in the low phase of the idle cycle that follows the burst.
   task automatic burst(input int port, input logic [63:0] addr, input int len,
                        input int err_beat, input int last_beat,
                        input bit toggle, input bit drop);
      int  hs_cnt;
      int  cyc;
      bit  done;
      bit  rr;
      logic [63:0] word;
      #1;
      check_val("req_ready", 64'(bus.req_ready), 64'(3'b001 << port));
      @(negedge clk);
      if (drop) bus.req_valid = '0;
      bus.arready_m = 1'b0;
      #1;
      check_val("arvalid", 64'(bus.arvalid_m), 64'd1);
      check_val("arid", 64'(bus.arid_m), 64'(port));
      check_val("araddr", bus.araddr_m, addr);
      check_val("arlen", 64'(bus.arlen_m), 64'(len));
      check_val("arsize", 64'(bus.arsize_m), 64'd6);
      check_val("busy_addr", 64'(busy), 64'd1);
      @(negedge clk);
      bus.arready_m = 1'b1;
      #1;
      check_val("araddr_hold", bus.araddr_m, addr);
      check_val("arvalid_hold", 64'(bus.arvalid_m), 64'd1);
      @(negedge clk);
      bus.arready_m = 1'b0;
      hs_cnt = 0;
      cyc    = 0;
      done   = 1'b0;
      while (!done && cyc < 64) begin
         rr   = toggle ? (cyc % 2 == 0) : 1'b1;
         word = 64'hD000_0000_0000_0000 | 64'(hs_cnt);
         bus.rsp_ready = rr ? (3'b001 << port) : 3'b000;
         bus.rvalid_m  = 1'b1;
         bus.rid_m     = 16'(port);
         bus.rdata_m   = {8{word}};
         bus.rresp_m   = (hs_cnt == err_beat) ? 2'd2 : 2'd0;
         bus.rlast_m   = (hs_cnt == last_beat);
         #1;
         check_val("rready", 64'(bus.rready_m), 64'(rr));
         check_val("rsp_valid", 64'(bus.rsp_valid), 64'(3'b001 << port));
         check_val("rsp_last", 64'(bus.rsp_last), 64'(hs_cnt == last_beat));
         check_val("rsp_err", 64'(bus.rsp_err), 64'(hs_cnt == err_beat));
         check_val("rsp_data", bus.rsp_data[63:0], word);
         if (rr) begin
            if (hs_cnt == last_beat) done = 1'b1;
            hs_cnt++;
         end
         cyc++;
         @(negedge clk);
      end
      if (!done) check_val("data_timeout", 64'd0, 64'd1);
      bus.rvalid_m  = 1'b0;
      bus.rlast_m   = 1'b0;
      bus.rresp_m   = 2'd0;
      bus.rsp_ready = '0;
      #1;
      check_val("busy_end", 64'(busy), 64'd0);
      check_val("rsp_valid_end", 64'(bus.rsp_valid), 64'd0);
      check_val("beats", 64'(hs_cnt), 64'(last_beat + 1));
      $display("burst port=%0d len=%0d beats=%0d err_sticky=%b", port, len, hs_cnt, err_sticky);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.rsp_ready = '0;
      bus.arready_m = 1'b0;
      bus.rid_m     = '0;
      bus.rdata_m   = '0;
      bus.rresp_m   = '0;
      bus.rlast_m   = 1'b0;
      bus.rvalid_m  = 1'b0;
      for (int p = 0; p < 3; p++) bus.req_addr[64*p +: 64] = 64'h1000 * (p + 1);
      bus.req_addr[64 +: 64] = 64'h40;

      // Reset state with every requester asserting
      repeat (2) @(negedge clk);
      bus.req_valid = 3'b111;
      #1;
      check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_arvalid", 64'(bus.arvalid_m), 64'd0);
      check_val("rst_rready", 64'(bus.rready_m), 64'd0);
      check_val("rst_err", 64'(err_sticky), 64'd0);

      // Port 1 alone, addr 0x40, single beat
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_valid = 3'b010;
      burst(1, 64'h40, 0, -1, 0, 1'b0, 1'b1);

      // Fresh reset, then all ports continuously requesting single beats
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_addr[64 +: 64] = 64'h2000;
      bus.req_valid = 3'b111;
      for (int i = 0; i < 6; i++)
         burst(i % 3, 64'h1000 * ((i % 3) + 1), 0, -1, 0, 1'b0, i == 5);

      // Port 0, four beats under toggling back-pressure
      bus.req_len[7:0] = 8'd3;
      bus.req_valid = 3'b001;
      burst(0, 64'h1000, 3, -1, 3, 1'b1, 1'b1);
      check_val("err_clean", 64'(err_sticky), 64'd0);

      // SLVERR on beat 2
      bus.req_valid = 3'b001;
      burst(0, 64'h1000, 3, 2, 3, 1'b0, 1'b1);
      check_val("err_rresp", 64'(err_sticky), 64'd1);

      // Early rlast on beat 1 of a four-beat burst from port 1
      bus.req_len[15:8] = 8'd3;
      bus.req_valid = 3'b010;
      burst(1, 64'h2000, 3, -1, 1, 1'b0, 1'b1);
      check_val("err_proto", 64'(err_sticky), 64'd3);

      // Port 2 burst interrupted by reset in the data phase
      bus.req_valid = 3'b100;
      #1;
      check_val("p2_req_ready", 64'(bus.req_ready), 64'b100);
      @(negedge clk);
      bus.req_valid = '0;
      bus.arready_m = 1'b1;
      @(negedge clk);
      bus.arready_m = 1'b0;
      bus.rvalid_m  = 1'b1;
      bus.rid_m     = 16'd2;
      bus.rsp_ready = 3'b100;
      #1;
      check_val("p2_rsp_valid", 64'(bus.rsp_valid), 64'b100);
      #1;
      rst_n = 1'b0;
      bus.req_valid = 3'b101;
      #1;
      check_val("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_val("arst_rready", 64'(bus.rready_m), 64'd0);
      check_val("arst_busy", 64'(busy), 64'd0);
      check_val("arst_arvalid", 64'(bus.arvalid_m), 64'd0);
      check_val("arst_req_ready", 64'(bus.req_ready), 64'd0);
      check_val("arst_err", 64'(err_sticky), 64'd0);
      @(negedge clk);
      bus.rvalid_m  = 1'b0;
      bus.rsp_ready = '0;
      rst_n = 1'b1;
      #1;
      check_val("post_rst_grant", 64'(bus.req_ready), 64'b001);
      @(posedge clk);
      #1;
      check_val("post_rst_busy", 64'(busy), 64'd1);
      check_val("post_rst_arid", 64'(bus.arid_m), 64'd0);
      $display("burst port=2 interrupted by reset, port 0 regranted");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter NPORT, default 3, number of read requesters (2..4).
REQ-002 Parameter IDW, default 16, AXI ID width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  NPORT  per-port burst request.
REQ-006 req_addr  in  64*NPORT  per-port byte address, port i at [64i+63:64i].
REQ-007 req_len  in  8*NPORT  per-port AXI burst length (beats-1).
REQ-008 req_ready  out  NPORT  one-hot request acceptance.
REQ-009 rsp_data  out  512  shared read data, valid only where rsp_valid set.
REQ-010 rsp_valid  out  NPORT  one-hot beat valid to granted port.
REQ-011 rsp_last  out  1  last beat of burst.
REQ-012 rsp_err  out  1  beat carries non-OKAY rresp.
REQ-013 rsp_ready  in  NPORT  per-port beat acceptance.
REQ-014 arid_m/araddr_m/arlen_m/arsize_m/arvalid_m  out  IDW/64/8/3/1  AXI AR channel.
REQ-015 arready_m  in  1  AXI AR ready.
REQ-016 rid_m/rdata_m/rresp_m/rlast_m/rvalid_m  in  IDW/512/2/1/1  AXI R channel.
REQ-017 rready_m  out  1  AXI R ready.
REQ-018 busy  out  1  high in ADDR or DATA.
REQ-019 err_sticky  out  2  bit0 rresp error seen, bit1 protocol error seen; cleared only by reset.

Function
REQ-020 Block SHALL implement FSM states IDLE, ADDR, DATA; exactly one burst outstanding at any time.
REQ-021 IDLE: if any req_valid, grant SHALL pick first set port scanning from (last_grant+1) mod NPORT upward, wrapping.
REQ-022 Grant cycle: req_ready SHALL be one-hot for winner only, combinational in IDLE; addr, len, index latched; next state ADDR.
REQ-023 IDLE with no req_valid: req_ready SHALL be all zero, state unchanged.
REQ-024 ADDR: arvalid_m=1, araddr_m/arlen_m latched values, arsize_m=3'd6, arid_m=zero-extended port index; all held stable until arready_m.
REQ-025 ADDR with arready_m=1: next state DATA; beat counter cleared to 0.
REQ-026 DATA: rready_m SHALL equal rsp_ready[granted]; rsp_valid[granted]=rvalid_m, other bits 0; rsp_data=rdata_m; rsp_last=rlast_m; rsp_err=(rresp_m!=0).
REQ-027 Each handshake (rvalid_m&rready_m) SHALL increment 8-bit beat counter.
REQ-028 Handshake with rlast_m=1: next state IDLE, last_grant updated to granted index; new grant earliest next cycle (one idle cycle between bursts).
REQ-029 Handshake with rresp_m!=0 SHALL set err_sticky[0]; burst continues.
REQ-030 err_sticky[1] SHALL set on handshake where rid_m!=arid_m, or rlast_m=1 with beat counter!=latched len, or beat counter==len with rlast_m=0; FSM still ends only on rlast_m.
REQ-031 Outside DATA: rready_m=0, rsp_valid=0; outside ADDR: arvalid_m=0.
REQ-032 Requester dropping req_valid after grant SHALL not affect the in-flight burst.
REQ-033 last_grant reset value NPORT-1 so port 0 wins first contended arbitration.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, last_grant=NPORT-1, beat counter 0, err_sticky 0, all outputs 0 (arvalid_m, rready_m, req_ready, rsp_valid, busy).
REQ-035 Reset mid-burst SHALL abandon burst with no further handshakes; first edge after rst_n high may grant.

Verification
REQ-036 Port1 only, addr 0x40, len 0; arready_m=1, one R beat rlast=1 -> arid_m=1, araddr_m=0x40, rsp_valid=3'b010 one cycle, busy falls after beat.
REQ-037 All 3 ports valid continuously, len 0 -> grant order 0,1,2,0,1,2.
REQ-038 Port0 len 3, rsp_ready toggled 1,0 -> exactly 4 handshakes, rready_m follows rsp_ready, rsp_last only on 4th.
REQ-039 rresp_m=2 on beat 2 of len-3 burst -> rsp_err high that beat, err_sticky=2'b01, burst completes.
REQ-040 rlast_m=1 on beat 1 of len-3 burst -> err_sticky[1]=1, FSM returns IDLE.
REQ-041 rst_n pulled low during DATA of port2 -> outputs 0 asynchronously; after release with ports 0,2 valid, port 0 granted.
